cam_capture_ctrl: RTL and testbench
===================================

Name: cam_capture_ctrl

Overview:
- Capture-side controller for the 8-bit YUV422 camera interface (PCLK, HREF, VSYNC, CAMDATA, ENABLE, RESOL).
- Enables the camera and selects its resolution. Aligns capture to a frame boundary and packs the UYVY byte stream into 32-bit words for a valid/ready write sink.
- Checks line and frame geometry, then reports frame completion and errors to the capture register block.

Parameters:
- VGA_HBYTES, 1280, bytes per active line at VGA (640 px x 2)
- SXGA_HBYTES, 2560, bytes per active line at SXGA (1280 px x 2)
- VGA_LINES, 480, active lines per VGA frame
- SXGA_LINES, 1024, active lines per SXGA frame

Ports:
- PCLK  in  1  camera pixel clock; the sole clock; all logic on posedge
- PRST  in  1  synchronous active-high reset
- CAPSTART  in  1  one-cycle start pulse
- CAPSTOP  in  1  one-cycle stop request; honoured at the end of the current frame
- CONTMODE  in  1  1 = continuous frames, 0 = single frame; sampled with CAPSTART
- RESOL_IN  in  2  requested resolution; 2'b00 = VGA, any other value = SXGA geometry
- HREF  in  1  camera line-valid
- VSYNC  in  1  camera frame sync, active high
- CAMDATA  in  8  camera byte
- ENABLE  out  1  camera enable
- RESOL  out  2  resolution latched at CAPSTART, driven to the camera
- WDATA  out  32  packed word; byte0 in [7:0], byte3 in [31:24] (U0,Y0,V1,Y1)
- WVALID  out  1  WDATA valid
- WREADY  in  1  sink accepts the word when WVALID && WREADY
- BUSY  out  1  state != IDLE
- FRAMEDONE  out  1  one-cycle pulse per completed frame
- LINECNT  out  11  active lines captured in the current frame
- ERR_OVF  out  1  sticky: word dropped because the output register was still full
- ERR_GEOM  out  1  sticky: line byte count or frame line count mismatch

Behaviour:
- Reset: state=IDLE, ENABLE=0, RESOL=0, WVALID=0, WDATA=0, BUSY=0, FRAMEDONE=0, LINECNT=0, ERR_*=0, byte lane=0.
- PRST asserted mid-frame aborts immediately: no FRAMEDONE, pending word discarded.
- CAMDATA, HREF and VSYNC change on the camera's negedge and are sampled on posedge with no synchroniser.
- HREF_d and VSYNC_d are 1-cycle registered copies, used for edge detection.
- States:
  - IDLE: on CAPSTART, latch RESOL<-RESOL_IN and CONTMODE, clear ERR_*, set ENABLE=1, go to WAIT_VS. CAPSTART in any other state is ignored.
  - WAIT_VS: wait for a VSYNC falling edge (VSYNC_d=1, VSYNC=0), then go to ACTIVE with LINECNT=0 and byte lane=0. Partial frames are never captured.
  - ACTIVE: each cycle with HREF=1, store CAMDATA into lane [lane*8+:8] and increment lane mod 4.
    - Lane 3 completes a word: if WVALID=0, or WVALID && WREADY in the same cycle, load WDATA and set WVALID=1 on the next cycle. Otherwise drop the word and set ERR_OVF.
    - Latency: byte3 sampled at edge N gives WVALID=1 after edge N+1.
    - HREF falling edge: the line byte count must equal HBYTES, otherwise set ERR_GEOM. Reset lane and the byte count to 0, then LINECNT++.
    - Frame end: when LINECNT reaches LINES, pulse FRAMEDONE. If CONTMODE=1 and no stop is pending, go to WAIT_VS; otherwise go to DONE.
    - A VSYNC rising edge in ACTIVE before LINECNT=LINES sets ERR_GEOM, pulses FRAMEDONE and takes the same exit.
  - DONE: stay until WVALID=0, then set ENABLE=0 and go to IDLE.
- WVALID drops on handshake unless a new word is loaded in the same cycle.
- CAPSTOP in WAIT_VS goes straight to DONE. CAPSTOP in ACTIVE sets stop-pending, cleared on IDLE.
- CAPSTART and CAPSTOP in the same IDLE cycle: start wins, stop is ignored.
- Arithmetic: byte counter 12 bits, LINECNT 11 bits, compared with ==, no wrap within legal frames.
- RESOL 2'b01 and 2'b10 both use SXGA geometry.

Decomposition:
- Shared package cam_pkg: RESOL encodings (VGA=2'b00, XGA=2'b01, SXGA=2'b10), geometry constants, and the state enum (IDLE, WAIT_VS, ACTIVE, DONE).
- One sub-module: cam_byte_packer. It owns lane/byte counting, word assembly, the output register, the WVALID/WREADY handshake and the overflow flag.
- The FSM and geometry checks stay in the top level.

Test Plan:
- Single-frame VGA with WREADY=1: exactly 153600 words, LINECNT=480, one FRAMEDONE, ERR_OVF=0 and ERR_GEOM=0, ENABLE returns to 0, first WDATA={Y1,V1,Y0,U0} of pixel pair 0.
- Single-frame SXGA (RESOL_IN=2'b10): 655360 words, 640 words per line, LINECNT=1024; RESOL_IN=2'b01 gives identical counts.
- Continuous mode with CAPSTOP during frame 2: exactly 2 FRAMEDONE pulses, then IDLE. CAPSTART while BUSY=1 is ignored.
- Backpressure: WREADY=0 for 8 consecutive words mid-line → ERR_OVF=1, 7 words lost. Clean frame counts are unaffected after WREADY returns to 1.
- Start mid-frame (CAPSTART while VSYNC=0 and HREF active): no WVALID until after the next VSYNC falling edge, then a full 153600-word frame.
- PRST asserted at line 100 with WVALID=1: next cycle all outputs are at reset values, no FRAMEDONE. A new CAPSTART captures a clean frame.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared definitions for the camera capture slice: resolution codes,
// default line/frame geometry and the capture FSM state encoding.
package cam_pkg;

    typedef enum logic [1:0] {
        RES_VGA  = 2'b00,
        RES_XGA  = 2'b01,
        RES_SXGA = 2'b10
    } resol_e;

    localparam int unsigned DEF_VGA_HBYTES  = 1280;
    localparam int unsigned DEF_SXGA_HBYTES = 2560;
    localparam int unsigned DEF_VGA_LINES   = 480;
    localparam int unsigned DEF_SXGA_LINES  = 1024;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_VS,
        ACTIVE,
        DONE
    } state_e;

    // Only the VGA code selects VGA geometry; every other code is SXGA-sized.
    function automatic logic is_vga(input logic [1:0] resol);
        return resol == RES_VGA;
    endfunction

endpackage

// File: rtl/cam_byte_packer.sv
// Packs camera bytes into 32-bit words (byte0 in [7:0]) and holds them in a
// single output register behind a valid/ready handshake.
module cam_byte_packer
    import cam_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_err_i,
    input  logic        lane_clr_i,
    input  logic        cap_i,
    input  logic [7:0]  data_i,
    input  logic        wready_i,
    output logic [31:0] wdata_o,
    output logic        wvalid_o,
    output logic [11:0] bytecnt_o,
    output logic        busy_o,
    output logic        err_ovf_o
);

    logic [1:0]  lane_q, lane_d;
    logic [11:0] cnt_q, cnt_d;
    logic [23:0] asm_q, asm_d;
    logic [31:0] word_q, word_d;
    logic        pend_q, pend_d;
    logic [31:0] wdata_q, wdata_d;
    logic        wvalid_q, wvalid_d;
    logic        ovf_q, ovf_d;

    // A completed word waits one cycle in word_q before the output register
    // decides load-or-drop, giving the byte3 -> WVALID latency of two edges.
    always_comb begin
        lane_d   = lane_q;
        cnt_d    = cnt_q;
        asm_d    = asm_q;
        word_d   = word_q;
        pend_d   = 1'b0;
        wdata_d  = wdata_q;
        wvalid_d = wvalid_q;
        ovf_d    = ovf_q;

        if (wvalid_q && wready_i) begin
            wvalid_d = 1'b0;
        end
        if (pend_q) begin
            if (!wvalid_q || wready_i) begin
                wdata_d  = word_q;
                wvalid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
        if (clr_err_i) begin
            ovf_d = 1'b0;
        end

        if (lane_clr_i) begin
            lane_d = '0;
            cnt_d  = '0;
        end else if (cap_i) begin
            lane_d = lane_q + 2'd1;
            cnt_d  = cnt_q + 12'd1;
            if (lane_q == 2'd3) begin
                word_d = {data_i, asm_q};
                pend_d = 1'b1;
            end else begin
                asm_d[8*lane_q +: 8] = data_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lane_q   <= '0;
            cnt_q    <= '0;
            asm_q    <= '0;
            word_q   <= '0;
            pend_q   <= 1'b0;
            wdata_q  <= '0;
            wvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            lane_q   <= lane_d;
            cnt_q    <= cnt_d;
            asm_q    <= asm_d;
            word_q   <= word_d;
            pend_q   <= pend_d;
            wdata_q  <= wdata_d;
            wvalid_q <= wvalid_d;
            ovf_q    <= ovf_d;
        end
    end

    assign wdata_o   = wdata_q;
    assign wvalid_o  = wvalid_q;
    assign bytecnt_o = cnt_q;
    assign busy_o    = wvalid_q | pend_q;
    assign err_ovf_o = ovf_q;

endmodule

// File: rtl/cam_capture_ctrl.sv
// Camera capture controller: frame-aligned start/stop sequencing, line and
// frame geometry checking, and status reporting around the byte packer.
module cam_capture_ctrl
    import cam_pkg::*;
#(
    parameter int unsigned VGA_HBYTES  = DEF_VGA_HBYTES,
    parameter int unsigned SXGA_HBYTES = DEF_SXGA_HBYTES,
    parameter int unsigned VGA_LINES   = DEF_VGA_LINES,
    parameter int unsigned SXGA_LINES  = DEF_SXGA_LINES
) (
    input  logic        PCLK,
    input  logic        PRST,
    input  logic        CAPSTART,
    input  logic        CAPSTOP,
    input  logic        CONTMODE,
    input  logic [1:0]  RESOL_IN,
    input  logic        HREF,
    input  logic        VSYNC,
    input  logic [7:0]  CAMDATA,
    output logic        ENABLE,
    output logic [1:0]  RESOL,
    output logic [31:0] WDATA,
    output logic        WVALID,
    input  logic        WREADY,
    output logic        BUSY,
    output logic        FRAMEDONE,
    output logic [10:0] LINECNT,
    output logic        ERR_OVF,
    output logic        ERR_GEOM
);

    localparam logic [11:0] VGA_HB  = 12'(VGA_HBYTES);
    localparam logic [11:0] SXGA_HB = 12'(SXGA_HBYTES);
    localparam logic [10:0] VGA_LN  = 11'(VGA_LINES);
    localparam logic [10:0] SXGA_LN = 11'(SXGA_LINES);

    state_e      state_q;
    logic        href_q, vsync_q;
    logic        enable_q, cont_q, stop_q, framedone_q, err_geom_q;
    logic [1:0]  resol_q;
    logic [10:0] linecnt_q;

    logic        active, href_fall, vs_fall, vs_rise, frame_end, cont_next;
    logic        pk_busy;
    logic [11:0] bytecnt, hbytes;
    logic [10:0] lines, linecnt_inc;

    assign active      = (state_q == ACTIVE);
    assign href_fall   = href_q & ~HREF;
    assign vs_fall     = vsync_q & ~VSYNC;
    assign vs_rise     = ~vsync_q & VSYNC;
    assign hbytes      = is_vga(resol_q) ? VGA_HB : SXGA_HB;
    assign lines       = is_vga(resol_q) ? VGA_LN : SXGA_LN;
    assign linecnt_inc = linecnt_q + 11'd1;
    assign frame_end   = href_fall && (linecnt_inc == lines);
    assign cont_next   = cont_q && !stop_q && !CAPSTOP;

    cam_byte_packer u_packer (
        .clk_i      (PCLK),
        .rst_i      (PRST),
        .clr_err_i  ((state_q == IDLE) && CAPSTART),
        .lane_clr_i (!active || href_fall),
        .cap_i      (active && HREF),
        .data_i     (CAMDATA),
        .wready_i   (WREADY),
        .wdata_o    (WDATA),
        .wvalid_o   (WVALID),
        .bytecnt_o  (bytecnt),
        .busy_o     (pk_busy),
        .err_ovf_o  (ERR_OVF)
    );

    always_ff @(posedge PCLK) begin
        if (PRST) begin
            state_q     <= IDLE;
            href_q      <= 1'b0;
            vsync_q     <= 1'b0;
            enable_q    <= 1'b0;
            cont_q      <= 1'b0;
            stop_q      <= 1'b0;
            framedone_q <= 1'b0;
            err_geom_q  <= 1'b0;
            resol_q     <= '0;
            linecnt_q   <= '0;
        end else begin
            href_q      <= HREF;
            vsync_q     <= VSYNC;
            framedone_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    stop_q <= 1'b0;
                    if (CAPSTART) begin
                        resol_q    <= RESOL_IN;
                        cont_q     <= CONTMODE;
                        err_geom_q <= 1'b0;
                        enable_q   <= 1'b1;
                        state_q    <= WAIT_VS;
                    end
                end
                WAIT_VS: begin
                    if (CAPSTOP) begin
                        state_q <= DONE;
                    end else if (vs_fall) begin
                        linecnt_q <= '0;
                        state_q   <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (CAPSTOP) begin
                        stop_q <= 1'b1;
                    end
                    if (href_fall) begin
                        linecnt_q <= linecnt_inc;
                        if (bytecnt != hbytes) begin
                            err_geom_q <= 1'b1;
                        end
                    end
                    // A VSYNC rise that is not the completing line's edge means a short frame.
                    if (frame_end || vs_rise) begin
                        framedone_q <= 1'b1;
                        state_q     <= cont_next ? WAIT_VS : DONE;
                        if (!frame_end) begin
                            err_geom_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (!pk_busy) begin
                        enable_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ENABLE    = enable_q;
    assign RESOL     = resol_q;
    assign BUSY      = (state_q != IDLE);
    assign FRAMEDONE = framedone_q;
    assign LINECNT   = linecnt_q;
    assign ERR_GEOM  = err_geom_q;

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Directed bench for cam_capture_ctrl using a reduced geometry
// (VGA 16 B x 3 lines, SXGA 40 B x 4 lines) so whole frames stay short.
module tb_cam_capture_ctrl;

    logic        PCLK, PRST, CAPSTART, CAPSTOP, CONTMODE;
    logic [1:0]  RESOL_IN;
    logic        HREF, VSYNC;
    logic [7:0]  CAMDATA;
    logic        ENABLE;
    logic [1:0]  RESOL;
    logic [31:0] WDATA;
    logic        WVALID, WREADY, BUSY, FRAMEDONE;
    logic [10:0] LINECNT;
    logic        ERR_OVF, ERR_GEOM;

    int checks   = 0;
    int failures = 0;
    logic [31:0] words_q[$];
    int fdone_cnt = 0;

    cam_capture_ctrl #(
        .VGA_HBYTES  (16),
        .SXGA_HBYTES (40),
        .VGA_LINES   (3),
        .SXGA_LINES  (4)
    ) dut (
        .PCLK      (PCLK),
        .PRST      (PRST),
        .CAPSTART  (CAPSTART),
        .CAPSTOP   (CAPSTOP),
        .CONTMODE  (CONTMODE),
        .RESOL_IN  (RESOL_IN),
        .HREF      (HREF),
        .VSYNC     (VSYNC),
        .CAMDATA   (CAMDATA),
        .ENABLE    (ENABLE),
        .RESOL     (RESOL),
        .WDATA     (WDATA),
        .WVALID    (WVALID),
        .WREADY    (WREADY),
        .BUSY      (BUSY),
        .FRAMEDONE (FRAMEDONE),
        .LINECNT   (LINECNT),
        .ERR_OVF   (ERR_OVF),
        .ERR_GEOM  (ERR_GEOM)
    );

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    // Handshakes and FRAMEDONE pulses, sampled mid-cycle after inputs settle.
    always @(negedge PCLK) begin
        #1;
        if (WVALID && WREADY) words_q.push_back(WDATA);
        if (FRAMEDONE) fdone_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic vsync_pulse();
        @(negedge PCLK) VSYNC = 1'b1;
        repeat (3) @(negedge PCLK);
        VSYNC = 1'b0;
        repeat (4) @(negedge PCLK);
    endtask

    // Byte value encodes position: line*64 + byte index.
    task automatic send_frame(input int nlines, input int nbytes, input int start_line,
                              input int stop_line, input int stall_line, input int rst_line);
        vsync_pulse();
        for (int l = 0; l < nlines; l++) begin
            for (int b = 0; b < nbytes; b++) begin
                @(negedge PCLK);
                HREF     = 1'b1;
                CAMDATA  = 8'(l * 64 + b);
                CAPSTART = (l == start_line) && (b == 0);
                CAPSTOP  = (l == stop_line) && (b == 0);
                if (l == stall_line && b == 6)  WREADY = 1'b0;
                if (l == stall_line && b == 37) WREADY = 1'b1;
                if (l == rst_line && b == 6) begin
                    PRST = 1'b1;
                    return;
                end
            end
            @(negedge PCLK);
            HREF     = 1'b0;
            CAMDATA  = '0;
            CAPSTART = 1'b0;
            CAPSTOP  = 1'b0;
            repeat (3) @(negedge PCLK);
        end
    endtask

    task automatic start(input logic [1:0] res, input logic cont, input logic stop_too);
        @(negedge PCLK);
        CAPSTART = 1'b1;
        CAPSTOP  = stop_too;
        RESOL_IN = res;
        CONTMODE = cont;
        @(negedge PCLK);
        CAPSTART = 1'b0;
        CAPSTOP  = 1'b0;
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (BUSY !== 1'b0 && n < 100) begin
            @(negedge PCLK);
            #1;
            n++;
        end
        check(tag, BUSY, 0);
    endtask

    int wb, fb;

    initial begin
        PRST = 1'b1; CAPSTART = 1'b0; CAPSTOP = 1'b0; CONTMODE = 1'b0;
        RESOL_IN = '0; HREF = 1'b0; VSYNC = 1'b0; CAMDATA = '0; WREADY = 1'b1;
        repeat (3) @(negedge PCLK);
        #1;
        check("reset_vector", {ENABLE, RESOL, WVALID, WDATA, BUSY, FRAMEDONE, LINECNT, ERR_OVF, ERR_GEOM}, 0);
        @(negedge PCLK) PRST = 1'b0;

        // Single VGA frame
        wb = words_q.size(); fb = fdone_cnt;
        start(2'b00, 1'b0, 1'b0);
        check("vga_busy", BUSY, 1);
        check("vga_enable", ENABLE, 1);
        send_frame(3, 16, -1, -1, -1, -1);
        wait_idle("vga_idle");
        check("vga_words", words_q.size() - wb, 12);
        check("vga_first", words_q[wb], 32'h03020100);
        check("vga_last", words_q[wb + 11], 32'h8F8E8D8C);
        check("vga_linecnt", LINECNT, 3);
        check("vga_fdone", fdone_cnt - fb, 1);
        check("vga_errs", {ERR_OVF, ERR_GEOM}, 0);
        check("vga_enable_off", ENABLE, 0);

        // SXGA via 2'b10
        wb = words_q.size(); fb = fdone_cnt;
        start(2'b10, 1'b0, 1'b0);
        check("sxga_resol", RESOL, 2'b10);
        send_frame(4, 40, -1, -1, -1, -1);
        wait_idle("sxga_idle");
        check("sxga_words", words_q.size() - wb, 40);
        check("sxga_line1_first", words_q[wb + 10], 32'h43424140);
        check("sxga_last", words_q[wb + 39], 32'hE7E6E5E4);
        check("sxga_linecnt", LINECNT, 4);
        check("sxga_errs", {ERR_OVF, ERR_GEOM}, 0);

        // XGA code uses SXGA geometry; CAPSTOP alongside CAPSTART is ignored
        wb = words_q.size(); fb = fdone_cnt;
        start(2'b01, 1'b0, 1'b1);
        check("xga_start_wins", BUSY, 1);
        check("xga_resol", RESOL, 2'b01);
        send_frame(4, 40, -1, -1, -1, -1);
        wait_idle("xga_idle");
        check("xga_words", words_q.size() - wb, 40);
        check("xga_linecnt", LINECNT, 4);
        check("xga_fdone", fdone_cnt - fb, 1);

        // Backpressure: 8 words complete while WREADY=0 on line 1, 7 are dropped
        wb = words_q.size(); fb = fdone_cnt;
        start(2'b10, 1'b0, 1'b0);
        send_frame(4, 40, -1, -1, 1, -1);
        wait_idle("ovf_idle");
        check("ovf_words", words_q.size() - wb, 33);
        check("ovf_kept_w1", words_q[wb + 11], 32'h47464544);
        check("ovf_kept_w9", words_q[wb + 12], 32'h67666564);
        check("ovf_flag", ERR_OVF, 1);
        check("ovf_geom", ERR_GEOM, 0);
        check("ovf_linecnt", LINECNT, 4);
        check("ovf_fdone", fdone_cnt - fb, 1);

        // Short frame: VSYNC rises after 2 of 3 lines
        wb = words_q.size(); fb = fdone_cnt;
        start(2'b00, 1'b0, 1'b0);
        check("short_ovf_cleared", ERR_OVF, 0);
        send_frame(2, 16, -1, -1, -1, -1);
        vsync_pulse();
        wait_idle("short_idle");
        check("short_geom", ERR_GEOM, 1);
        check("short_fdone", fdone_cnt - fb, 1);
        check("short_linecnt", LINECNT, 2);
        check("short_words", words_q.size() - wb, 8);

        // Continuous mode, stop during frame 2, busy CAPSTART ignored
        wb = words_q.size(); fb = fdone_cnt;
        start(2'b00, 1'b1, 1'b0);
        check("cont_geom_cleared", ERR_GEOM, 0);
        send_frame(3, 16, -1, -1, -1, -1);
        check("cont_f1_busy", BUSY, 1);
        check("cont_f1_fdone", fdone_cnt - fb, 1);
        start(2'b10, 1'b0, 1'b0);
        check("cont_restart_ignored", RESOL, 2'b00);
        send_frame(3, 16, -1, 1, -1, -1);
        wait_idle("cont_idle");
        send_frame(3, 16, -1, -1, -1, -1);
        check("cont_fdone", fdone_cnt - fb, 2);
        check("cont_words", words_q.size() - wb, 24);
        check("cont_enable_off", ENABLE, 0);
        check("cont_still_idle", BUSY, 0);

        // Start in the middle of a frame: nothing until the next VSYNC fall
        wb = words_q.size(); fb = fdone_cnt;
        RESOL_IN = 2'b00; CONTMODE = 1'b0;
        send_frame(3, 16, 1, -1, -1, -1);
        check("mid_no_words", words_q.size() - wb, 0);
        check("mid_waiting", BUSY, 1);
        send_frame(3, 16, -1, -1, -1, -1);
        wait_idle("mid_idle");
        check("mid_words", words_q.size() - wb, 12);
        check("mid_first", words_q[wb], 32'h03020100);
        check("mid_fdone", fdone_cnt - fb, 1);

        // Reset mid-frame with a word held in the output register
        fb = fdone_cnt;
        WREADY = 1'b0;
        start(2'b00, 1'b0, 1'b0);
        send_frame(3, 16, -1, -1, -1, 1);
        #1;
        check("prst_pre_wvalid", WVALID, 1);
        @(negedge PCLK);
        #1;
        check("prst_vector", {ENABLE, RESOL, WVALID, WDATA, BUSY, FRAMEDONE, LINECNT, ERR_OVF, ERR_GEOM}, 0);
        @(negedge PCLK);
        PRST = 1'b0; HREF = 1'b0; CAMDATA = '0; WREADY = 1'b1;
        wb = words_q.size();
        repeat (5) @(negedge PCLK);
        #1;
        check("prst_no_words", words_q.size() - wb, 0);
        check("prst_no_fdone", fdone_cnt - fb, 0);
        wb = words_q.size(); fb = fdone_cnt;
        start(2'b00, 1'b0, 1'b0);
        send_frame(3, 16, -1, -1, -1, -1);
        wait_idle("post_rst_idle");
        check("post_rst_words", words_q.size() - wb, 12);
        check("post_rst_fdone", fdone_cnt - fb, 1);
        check("post_rst_errs", {ERR_OVF, ERR_GEOM}, 0);
        check("post_rst_linecnt", LINECNT, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
